sfft_stream_decoder: RTL and testbench

//  Back end of the scaled stochastic FFT: turns the NUMINPUTS real/imag output bitstreams into

---
 rtl/sfft_stream_decoder.sv | 140 ++++++++++++++
 tb/tb_sfft_stream_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfft_stream_decoder.sv
// Stochastic FFT back end: counts ones per real/imag bitstream over 2**BITWIDTH enabled cycles.
// Optional macro SFFT_DEC_BIPOLAR_EN: results become two's complement (count - 2**(BITWIDTH-1)).
module sfft_stream_decoder #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned NUMINPUTS = 8,
  parameter int unsigned LOG2N     = 3
) (
  input  logic                             iClk,
  input  logic                             iRstN,
  input  logic                             iEn,
  input  logic                             iClr,
  input  logic                             iStart,
  input  logic [NUMINPUTS-1:0]             iReal,
  input  logic [NUMINPUTS-1:0]             iImg,
  output logic [NUMINPUTS*(BITWIDTH+1)-1:0] oRealVal,
  output logic [NUMINPUTS*(BITWIDTH+1)-1:0] oImgVal,
  output logic                             oValid,
  input  logic                             iReady,
  output logic                             oBusy
);

  localparam int unsigned RW = BITWIDTH + 1;
`ifdef SFFT_DEC_BIPOLAR_EN
  localparam logic [RW-1:0] BIAS = RW'(1) << (BITWIDTH - 1);
`else
  localparam logic [RW-1:0] BIAS = '0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                     state_q;
  logic [BITWIDTH-1:0]        cnt_q;
  logic [RW-1:0]              acc_re_q [NUMINPUTS];
  logic [RW-1:0]              acc_im_q [NUMINPUTS];
  logic [RW-1:0]              acc_re_d [NUMINPUTS];
  logic [RW-1:0]              acc_im_d [NUMINPUTS];
  logic [NUMINPUTS*RW-1:0]    res_re_d, res_im_d;
  logic [NUMINPUTS*RW-1:0]    real_q, img_q;
  logic                       valid_q, busy_q;

  // LOG2N only documents the scaling the consumer must undo.
  logic unused_log2n;
  assign unused_log2n = (LOG2N != 0);

  always_comb begin
    res_re_d = '0;
    res_im_d = '0;
    for (int unsigned k = 0; k < NUMINPUTS; k++) begin
      acc_re_d[k] = acc_re_q[k] + RW'(iReal[k]);
      acc_im_d[k] = acc_im_q[k] + RW'(iImg[k]);
      // Bias is applied only on the way out; accumulators stay raw counts.
      res_re_d[k*RW +: RW] = acc_re_d[k] - BIAS;
      res_im_d[k*RW +: RW] = acc_im_d[k] - BIAS;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      real_q  <= '0;
      img_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned k = 0; k < NUMINPUTS; k++) begin
        acc_re_q[k] <= '0;
        acc_im_q[k] <= '0;
      end
    end else if (iClr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      real_q  <= '0;
      img_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned k = 0; k < NUMINPUTS; k++) begin
        acc_re_q[k] <= '0;
        acc_im_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q <= ACCUM;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < NUMINPUTS; k++) begin
              acc_re_q[k] <= '0;
              acc_im_q[k] <= '0;
            end
          end
        end
        ACCUM: begin
          if (iEn) begin
            cnt_q <= cnt_q + 1'b1;
            for (int unsigned k = 0; k < NUMINPUTS; k++) begin
              acc_re_q[k] <= acc_re_d[k];
              acc_im_q[k] <= acc_im_d[k];
            end
            // Counter at all-ones means this enabled cycle is the final sample.
            if (cnt_q == '1) begin
              real_q  <= res_re_d;
              img_q   <= res_im_d;
              state_q <= HOLD;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (iReady) begin
            valid_q <= 1'b0;
            if (iStart) begin
              state_q <= ACCUM;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              for (int unsigned k = 0; k < NUMINPUTS; k++) begin
                acc_re_q[k] <= '0;
                acc_im_q[k] <= '0;
              end
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oRealVal = real_q;
  assign oImgVal  = img_q;
  assign oValid   = valid_q;
  assign oBusy    = busy_q;

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Randomized self-checking bench for sfft_stream_decoder (BITWIDTH=4, NUMINPUTS=8).
module tb_sfft_stream_decoder;
  localparam int BW  = 4;
  localparam int NI  = 8;
  localparam int RW  = BW + 1;
  localparam int WIN = 1 << BW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, clr, start, ready;
  logic [NI-1:0]     re_in, im_in;
  logic [NI*RW-1:0]  re_out, im_out;
  logic              valid, busy;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_re [NI];
  logic [RW-1:0] exp_im [NI];

  sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI), .LOG2N(3)) dut (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iStart(start),
    .iReal(re_in), .iImg(im_in), .oRealVal(re_out), .oImgVal(im_out),
    .oValid(valid), .iReady(ready), .oBusy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] field(input logic [NI*RW-1:0] bus, input int k);
    return bus[k*RW +: RW];
  endfunction

  // Reference mapping from a ones-count to the expected field encoding.
  function automatic logic [RW-1:0] encode(input int ones);
`ifdef SFFT_DEC_BIPOLAR_EN
    return RW'(ones - WIN / 2);
`else
    return RW'(ones);
`endif
  endfunction

  task automatic check_fields(input string name);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (field(re_out, k) !== exp_re[k]) begin
        errors++;
        $display("FAIL %s real[%0d]: got %0d expected %0d", name, k, field(re_out, k), exp_re[k]);
      end
      checks++;
      if (field(im_out, k) !== exp_im[k]) begin
        errors++;
        $display("FAIL %s imag[%0d]: got %0d expected %0d", name, k, field(im_out, k), exp_im[k]);
      end
    end
  endtask

  // mode 0: all ones; 1: real alternating, imag zero; 2: random bits and random enable
  task automatic run_window(input int mode, input bit issue_start, input int stall_at,
                            input int stall_len, input string name, output int cycles);
    int ones_re [NI];
    int ones_im [NI];
    int samples, stall_left;
    bit e;
    logic [NI-1:0] r, m;
    for (int k = 0; k < NI; k++) begin ones_re[k] = 0; ones_im[k] = 0; end
    if (issue_start) begin
      start = 1'b1; en = 1'b1; re_in = NI'($urandom); im_in = NI'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    samples = 0; cycles = 0; stall_left = stall_len;
    while (samples < WIN && cycles < 200) begin
      e = 1'b1;
      if (samples == stall_at && stall_left > 0) begin e = 1'b0; stall_left--; end
      if (mode == 2 && $urandom_range(0, 3) == 0) e = 1'b0;
      case (mode)
        0:       begin r = '1; m = '1; end
        1:       begin r = (samples % 2 == 0) ? '1 : '0; m = '0; end
        default: begin r = NI'($urandom); m = NI'($urandom); end
      endcase
      en = e; re_in = r; im_in = m;
      if (e) begin
        for (int k = 0; k < NI; k++) begin
          ones_re[k] += int'(r[k]);
          ones_im[k] += int'(m[k]);
        end
        samples++;
      end
      @(negedge clk);
      cycles++;
      if (samples < WIN) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++; $display("FAIL %s early_valid: got %b expected 0 at sample %0d", name, valid, samples);
        end
      end
    end
    en = 1'b0;
    checks++;
    if (samples < WIN) begin
      errors++; $display("FAIL %s timeout: got %0d samples expected %0d", name, samples, WIN);
    end
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s done_flags: got valid=%b busy=%b expected valid=1 busy=0", name, valid, busy);
    end
    for (int k = 0; k < NI; k++) begin
      exp_re[k] = encode(ones_re[k]);
      exp_im[k] = encode(ones_im[k]);
    end
    check_fields(name);
  endtask

  task automatic accept(input string name);
    ready = 1'b1; start = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s accept: got valid=%b busy=%b expected 0 0", name, valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; start = 1'b0; ready = 1'b0; re_in = '0; im_in = '0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || re_out !== '0 || im_out !== '0) begin
      errors++; $display("FAIL reset_state: got valid=%b busy=%b re=%h im=%h expected all 0", valid, busy, re_out, im_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    int c;
    run_window(0, 1'b1, -1, 0, "all_ones", c);
    checks++;
    if (c !== WIN) begin
      errors++; $display("FAIL latency: got %0d cycles expected %0d", c, WIN);
    end
    accept("all_ones");
    run_window(1, 1'b1, -1, 0, "alternating", c);
    accept("alternating");
    for (int i = 0; i < 3; i++) begin
      run_window(2, 1'b1, -1, 0, "random", c);
      accept("random");
    end
  endtask

  task automatic test_stall();
    int c0, c1;
    run_window(0, 1'b1, -1, 0, "nostall", c0);
    accept("nostall");
    run_window(0, 1'b1, 7, 5, "stall", c1);
    checks++;
    if (c1 !== c0 + 5) begin
      errors++; $display("FAIL stall_latency: got %0d cycles expected %0d", c1, c0 + 5);
    end
    accept("stall");
  endtask

  task automatic test_back_to_back();
    int c;
    run_window(2, 1'b1, -1, 0, "hold_win", c);
    for (int i = 0; i < 10; i++) begin
      ready = 1'b0; en = 1'(($urandom)); start = 1'(($urandom));
      re_in = NI'($urandom); im_in = NI'($urandom);
      @(negedge clk);
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL hold_valid: got %b expected 1", valid);
      end
      check_fields("hold_stable");
    end
    ready = 1'b1; start = 1'b1; en = 1'b0;
    @(negedge clk);
    ready = 1'b0; start = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL handshake_restart: got valid=%b busy=%b expected 0 1", valid, busy);
    end
    run_window(2, 1'b0, -1, 0, "restart_win", c);
    accept("restart_win");
  endtask

  task automatic test_clear();
    int c;
    start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      re_in = NI'($urandom); im_in = NI'($urandom);
      @(negedge clk);
    end
    clr = 1'b1; start = 1'b1; ready = 1'b1; re_in = '1; im_in = '1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0; ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || re_out !== '0 || im_out !== '0) begin
      errors++; $display("FAIL clear: got busy=%b valid=%b re=%h im=%h expected all 0", busy, valid, re_out, im_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL clear_idle: got valid=%b busy=%b expected 0 0", valid, busy);
      end
    end
    en = 1'b0;
    run_window(2, 1'b1, -1, 0, "after_clear", c);
    accept("after_clear");
  endtask

  task automatic test_async_reset();
    int c;
    run_window(0, 1'b1, -1, 0, "pre_reset", c);
    accept("pre_reset");
    start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || re_out !== '0 || im_out !== '0) begin
      errors++; $display("FAIL async_reset: got valid=%b busy=%b re=%h im=%h expected all 0", valid, busy, re_out, im_out);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
